// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the fetch (IF) and data (DM) stages.
// DM has priority, IF is forced through after MAX_DM_STREAK DM grants, and every access is timeout-bounded.
module unified_mem_arbiter #(
  parameter int             AW            = 32,
  parameter int             DW            = 32,
  parameter int             MAX_DM_STREAK = 4,
  parameter int             TIMEOUT       = 16,
  parameter logic [DW-1:0]  ERR_DATA      = DW'(32'h00000013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic            dm_done,
  output logic [DW-1:0]   dm_rdata,
  output logic            stall_f,
  output logic            stall_m,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            bus_err
);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic          if_m, dm_m, force_if, busy;
  logic          grant_if, grant_dm, finish, timed_out;

  // A port whose done is high this cycle is finishing, not asking again.
  assign if_m     = if_req & ~if_done;
  assign dm_m     = dm_req & ~dm_done;
  assign force_if = if_m && (streak == SW'(MAX_DM_STREAK));
  assign busy     = (state != IDLE);
  assign mem_req  = busy;
  assign stall_f  = if_req & ~if_done;
  assign stall_m  = dm_req & ~dm_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (dm_m && !force_if) begin
          grant_dm  = 1'b1;
          state_nxt = BUSY_DM;
        end else if (if_m) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        timed_out = !mem_ack && (tcnt == TW'(TIMEOUT - 1));
        finish    = mem_ack || timed_out;
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      bus_err   <= 1'b0;
      streak    <= '0;
      tcnt      <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (grant_dm) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
        tcnt      <= '0;
        if (!if_m)                                 streak <= '0;
        else if (streak != SW'(MAX_DM_STREAK))     streak <= streak + 1'b1;
      end else if (grant_if) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
        tcnt      <= '0;
        streak    <= '0;
      end else if (busy) begin
        // wraps harmlessly on the finishing cycle; cleared again at the next grant
        tcnt <= tcnt + 1'b1;
      end
      if (finish) begin
        mem_we <= 1'b0;
        if (state == BUSY_IF) begin
          if_done  <= 1'b1;
          if_rdata <= timed_out ? ERR_DATA : mem_rdata;
        end else begin
          dm_done  <= 1'b1;
          dm_rdata <= timed_out ? ERR_DATA : mem_rdata;
        end
        if (timed_out) bus_err <= 1'b1;
      end
    end
  end
endmodule
